// File: rtl/load_store_unit_if.sv
// Purpose : CPU-side request/response and memory-side bus for the load/store unit.
// Latency : n/a (signal bundle only).
// Backpressure: the CPU holds req_valid_i until done_o; the memory completes with mem_ack_i.
// Ports   : req_valid_i, mem_wr_en_i, funct3_i, addr_i, wr_data_i -> LSU (CPU request)
//           rd_data_o, done_o, err_o, stall_o                      <- LSU (CPU response)
//           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o <- LSU (memory request)
//           mem_ack_i, mem_rdata_i                                 -> LSU (memory response)
interface load_store_unit_if;
  logic        req_valid_i;
  logic        mem_wr_en_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wr_data_i;
  logic [31:0] rd_data_o;
  logic        done_o;
  logic        err_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  // LSU view
  modport slave (
    input  req_valid_i, mem_wr_en_i, funct3_i, addr_i, wr_data_i,
    input  mem_ack_i, mem_rdata_i,
    output rd_data_o, done_o, err_o, stall_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

  // CPU + memory view
  modport master (
    output req_valid_i, mem_wr_en_i, funct3_i, addr_i, wr_data_i,
    output mem_ack_i, mem_rdata_i,
    input  rd_data_o, done_o, err_o, stall_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );
endinterface

// File: rtl/load_store_unit.sv
// Purpose : RV32I load/store unit: lane enables, store replication, load extraction, timeout.
// Latency : 3 cycles accept->done_o with an immediate ack; 2 for rejected (illegal/misaligned) accesses.
// Backpressure: stall_o holds the pipeline until done_o; waits on mem_ack_i up to TIMEOUT_CYCLES.
// Ports   : clk_i, rst_n_i (sync, active-low); bus = load_store_unit_if.slave (CPU + memory sides).
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  load_store_unit_if.slave bus
);

  localparam logic [7:0] L_TIMEOUT = 8'(TIMEOUT_CYCLES);

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_done, r_err, r_mem_req, r_mem_we;
  logic [31:0] r_rd_data, r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [7:0]  r_cnt;

  logic        w_bad, w_accept, w_reject, w_ack_done, w_timeout;
  logic [7:0]  w_cnt_inc;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Request decode: illegal funct3 or misaligned halfword/word is rejected without a memory access.
  always_comb begin
    w_bad = 1'b0;
    case (bus.funct3_i)
      F_B, F_BU: w_bad = 1'b0;
      F_H, F_HU: w_bad = bus.addr_i[0];
      F_W:       w_bad = (bus.addr_i[1:0] != 2'b00);
      default:   w_bad = 1'b1;
    endcase
  end

  // Lane enables and store-data replication so every byte lane carries the right data.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.wr_data_i;
    case (bus.funct3_i)
      F_B, F_BU: begin
        w_be    = 4'b0001 << bus.addr_i[1:0];
        w_wdata = {4{bus.wr_data_i[7:0]}};
      end
      F_H, F_HU: begin
        w_be    = 4'b0011 << {bus.addr_i[1], 1'b0};
        w_wdata = {2{bus.wr_data_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = bus.wr_data_i;
      end
    endcase
  end

  // Load extraction uses the registered request fields since the CPU inputs may not be trusted mid-access.
  always_comb begin
    w_byte = bus.mem_rdata_i[7:0];
    case (r_addr_lo)
      2'd0:    w_byte = bus.mem_rdata_i[7:0];
      2'd1:    w_byte = bus.mem_rdata_i[15:8];
      2'd2:    w_byte = bus.mem_rdata_i[23:16];
      default: w_byte = bus.mem_rdata_i[31:24];
    endcase
    w_half = r_addr_lo[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
    case (r_funct3)
      F_B:     w_load = {{24{w_byte[7]}}, w_byte};
      F_H:     w_load = {{16{w_half[15]}}, w_half};
      F_BU:    w_load = {24'd0, w_byte};
      F_HU:    w_load = {16'd0, w_half};
      default: w_load = bus.mem_rdata_i;
    endcase
  end

  // Saturating wait counter increment.
  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_ack_done  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          w_accept    = ~w_bad;
          w_reject    = w_bad;
          w_state_nxt = w_bad ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        // An ack wins over a timeout landing in the same cycle.
        if (bus.mem_ack_i) begin
          w_ack_done  = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_cnt_inc >= L_TIMEOUT) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_rd_data   <= 32'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'd0;
      r_funct3    <= 3'd0;
      r_addr_lo   <= 2'd0;
      r_cnt       <= 8'd0;
    end else begin
      // done/err are single-cycle pulses
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_accept) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= bus.mem_wr_en_i;
        r_mem_addr  <= {bus.addr_i[31:2], 2'b00};
        r_mem_wdata <= w_wdata;
        r_mem_be    <= w_be;
        r_funct3    <= bus.funct3_i;
        r_addr_lo   <= bus.addr_i[1:0];
        r_cnt       <= 8'd0;
      end
      if (w_reject || w_timeout) begin
        r_done    <= 1'b1;
        r_err     <= 1'b1;
        r_rd_data <= 32'd0;
      end
      if (w_ack_done) begin
        r_done <= 1'b1;
        if (!r_mem_we) r_rd_data <= w_load;
      end
      if (w_ack_done || w_timeout) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
      end else if (r_state == S_REQ) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign bus.rd_data_o   = r_rd_data;
  assign bus.done_o      = r_done;
  assign bus.err_o       = r_err;
  assign bus.stall_o     = bus.req_valid_i & ~r_done;
  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_mem_wdata;
  assign bus.mem_be_o    = r_mem_be;

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;

  logic clk_i = 1'b0;
  logic rst_n_i;
  always #5 clk_i = ~clk_i;

  load_store_unit_if bus();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        mem;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;
    int          reqc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rd;

  // observations of the last access
  logic        ob_done, ob_err, ob_we, ob_stable, ob_stall_bad, ob_pulse_bad;
  logic [31:0] ob_rd, ob_rd_held, ob_addr, ob_wdata;
  logic [3:0]  ob_be;
  int          ob_lat, ob_reqc;

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lo +: 8];
    h = w[16*lo[1] +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      3'b000, 3'b100: return 4'b0001 << lo;
      3'b001, 3'b101: return lo[1] ? 4'b1100 : 4'b0011;
      default:        return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000, 3'b100: return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      3'b001, 3'b101: return {wd[15:0], wd[15:0]};
      default:        return wd;
    endcase
  endfunction

  // Acts as CPU and memory for one access; called at negedge+1 in IDLE and returns at negedge+1 in IDLE.
  // ack_at = index of the REQ cycle that gets mem_ack_i (-1 = never). Latency counts edges after the presenting cycle.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdata, input int ack_at);
    ob_done = 0; ob_err = 0; ob_we = 0; ob_stable = 1; ob_stall_bad = 0; ob_pulse_bad = 0;
    ob_rd = '0; ob_rd_held = '0; ob_addr = '0; ob_wdata = '0; ob_be = '0; ob_lat = -1; ob_reqc = 0;
    bus.req_valid_i = 1'b1;
    bus.mem_wr_en_i = we;
    bus.funct3_i    = f3;
    bus.addr_i      = addr;
    bus.wr_data_i   = wd;
    bus.mem_rdata_i = rdata;
    bus.mem_ack_i   = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (bus.done_o === 1'b1) begin
        ob_done = 1; ob_lat = cyc; ob_err = bus.err_o; ob_rd = bus.rd_data_o;
        if (bus.stall_o !== 1'b0) ob_stall_bad = 1;
        break;
      end
      if (bus.stall_o !== 1'b1) ob_stall_bad = 1;
      if (bus.mem_req_o === 1'b1) begin
        if (ob_reqc == 0) begin
          ob_we = bus.mem_we_o; ob_addr = bus.mem_addr_o; ob_wdata = bus.mem_wdata_o; ob_be = bus.mem_be_o;
        end else if ({ob_we, ob_addr, ob_wdata, ob_be} !== {bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o}) begin
          ob_stable = 0;
        end
        bus.mem_ack_i = (ob_reqc == ack_at);
        ob_reqc++;
      end else begin
        bus.mem_ack_i = 1'b0;
      end
      @(negedge clk_i);
    end
    bus.req_valid_i = 1'b0;
    bus.mem_ack_i   = 1'b0;
    if (ob_done) begin
      @(negedge clk_i);
      #1;
      if (bus.done_o !== 1'b0) ob_pulse_bad = 1;
      ob_rd_held = bus.rd_data_o;
    end
  endtask

  // Expected result of a legal access, built from the reference functions.
  task automatic push_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdata, input int ack_at);
    exp_t e;
    e.err   = 0;
    e.mem   = 1;
    e.we    = we;
    e.addr  = {addr[31:2], 2'b00};
    e.be    = ref_be(f3, addr[1:0]);
    e.wdata = ref_wdata(f3, wd);
    e.rd    = we ? model_rd : ref_load(f3, addr[1:0], rdata);
    e.lat   = 2 + ack_at;
    e.reqc  = ack_at + 1;
    model_rd = e.rd;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n_i = 1'b0;
    bus.req_valid_i = 0; bus.mem_wr_en_i = 0; bus.funct3_i = 0; bus.addr_i = 0;
    bus.wr_data_i = 0; bus.mem_ack_i = 0; bus.mem_rdata_i = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); #1;
    checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.done_o, bus.err_o, bus.stall_o} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: req/we/done/err/stall=%b expected 00000",
                         {bus.mem_req_o, bus.mem_we_o, bus.done_o, bus.err_o, bus.stall_o});
    end
    checks++;
    if ({bus.rd_data_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o} !== 100'b0) begin
      errors++; $display("FAIL reset_data: rd=%h addr=%h wdata=%h be=%b expected all zero",
                         bus.rd_data_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o);
    end
    rst_n_i  = 1'b1;
    model_rd = 32'd0;
    @(negedge clk_i); #1;
  endtask

  task automatic test_store_word();
    exp_t e;
    // SW 0x100: done in the third cycle counting the presenting cycle -> latency 2
    push_legal(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    run_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    e = sb.pop_front();
    checks++; if (!ob_done || ob_lat != e.lat) begin errors++; $display("FAIL sw_latency: got %0d done=%0b expected %0d", ob_lat, ob_done, e.lat); end
    checks++; if (ob_err !== e.err) begin errors++; $display("FAIL sw_err: got %b expected %b", ob_err, e.err); end
    checks++; if (ob_rd !== e.rd) begin errors++; $display("FAIL sw_rd: got %h expected %h", ob_rd, e.rd); end
    checks++; if ({ob_we, ob_be, ob_addr, ob_wdata} !== {e.we, e.be, e.addr, e.wdata} || !ob_stable)
      begin errors++; $display("FAIL sw_bus: we=%b be=%b addr=%h wdata=%h stable=%b expected we=%b be=%b addr=%h wdata=%h",
                               ob_we, ob_be, ob_addr, ob_wdata, ob_stable, e.we, e.be, e.addr, e.wdata); end
    checks++; if (ob_stall_bad || ob_pulse_bad || ob_reqc != e.reqc)
      begin errors++; $display("FAIL sw_handshake: stall_bad=%b pulse_bad=%b req_cycles=%0d expected 0 0 %0d", ob_stall_bad, ob_pulse_bad, ob_reqc, e.reqc); end
  endtask

  task automatic test_loads();
    exp_t e;
    logic [2:0]  f3s   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] addrs [6] = '{32'h103, 32'h103, 32'h106, 32'h104, 32'h108, 32'h101};
    logic [31:0] rds   [6] = '{32'h80FFFF7F, 32'h80FFFF7F, 32'h80017FFF, 32'h80017FFF, 32'h89ABCDEF, 32'h0000A500};
    logic [31:0] want  [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00007FFF, 32'h89ABCDEF, 32'hFFFFFFA5};
    logic [3:0]  wbe   [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b1111, 4'b0010};
    for (int i = 0; i < 6; i++) begin
      push_legal(1'b0, f3s[i], addrs[i], 32'h11223344, rds[i], i % 3);
      run_access(1'b0, f3s[i], addrs[i], 32'h11223344, rds[i], i % 3);
      e = sb.pop_front();
      checks++; if (!ob_done || ob_lat != e.lat) begin errors++; $display("FAIL load%0d_latency: got %0d done=%0b expected %0d", i, ob_lat, ob_done, e.lat); end
      checks++; if (ob_rd !== want[i] || ob_rd !== e.rd || ob_rd_held !== want[i])
        begin errors++; $display("FAIL load%0d_data: got %h held %h expected %h", i, ob_rd, ob_rd_held, want[i]); end
      checks++; if (ob_be !== wbe[i] || ob_we !== 1'b0 || ob_addr !== e.addr || ob_err !== 1'b0 || !ob_stable)
        begin errors++; $display("FAIL load%0d_bus: be=%b we=%b addr=%h err=%b stable=%b expected be=%b we=0 addr=%h err=0",
                                 i, ob_be, ob_we, ob_addr, ob_err, ob_stable, wbe[i], e.addr); end
      checks++; if (ob_stall_bad || ob_pulse_bad || ob_reqc != e.reqc)
        begin errors++; $display("FAIL load%0d_handshake: stall_bad=%b pulse_bad=%b req_cycles=%0d expected 0 0 %0d", i, ob_stall_bad, ob_pulse_bad, ob_reqc, e.reqc); end
    end
  endtask

  task automatic test_store_half();
    exp_t e;
    push_legal(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 1);
    run_access(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 1);
    e = sb.pop_front();
    checks++; if (ob_be !== 4'b1100 || ob_wdata !== 32'hABCDABCD || ob_we !== 1'b1 || !ob_stable)
      begin errors++; $display("FAIL sh_bus: be=%b wdata=%h we=%b stable=%b expected be=1100 wdata=abcdabcd we=1", ob_be, ob_wdata, ob_we, ob_stable); end
    checks++; if (!ob_done || ob_lat != e.lat || ob_rd !== e.rd || ob_err !== 1'b0)
      begin errors++; $display("FAIL sh_result: lat=%0d rd=%h err=%b expected lat=%0d rd=%h err=0", ob_lat, ob_rd, ob_err, e.lat, e.rd); end
  endtask

  task automatic test_rejects();
    exp_t e;
    logic        wes   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s   [4] = '{3'b101, 3'b011, 3'b010, 3'b110};
    logic [31:0] addrs [4] = '{32'h101, 32'h100, 32'h102, 32'h200};
    for (int i = 0; i < 4; i++) begin
      e.err = 1; e.mem = 0; e.rd = 32'd0; e.lat = 1; e.reqc = 0;
      e.we = 0; e.addr = 0; e.be = 0; e.wdata = 0;
      model_rd = 32'd0;
      sb.push_back(e);
      run_access(wes[i], f3s[i], addrs[i], 32'hCAFEF00D, 32'h12345678, 0);
      e = sb.pop_front();
      checks++; if (!ob_done || ob_lat != e.lat || ob_err !== e.err)
        begin errors++; $display("FAIL reject%0d_err: lat=%0d done=%0b err=%b expected lat=%0d err=1", i, ob_lat, ob_done, ob_err, e.lat); end
      checks++; if (ob_reqc != 0 || ob_rd !== e.rd || ob_rd_held !== e.rd || ob_pulse_bad)
        begin errors++; $display("FAIL reject%0d_noaccess: req_cycles=%0d rd=%h held=%h pulse_bad=%b expected 0 0 0 0", i, ob_reqc, ob_rd, ob_rd_held, ob_pulse_bad); end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    e.err = 1; e.mem = 1; e.rd = 32'd0; e.lat = 5; e.reqc = 4;
    e.we = 0; e.addr = 32'h200; e.be = 4'b1111; e.wdata = 32'h0;
    model_rd = 32'd0;
    sb.push_back(e);
    run_access(1'b0, 3'b010, 32'h200, 32'h0, 32'h5555AAAA, -1);
    e = sb.pop_front();
    checks++; if (ob_reqc != e.reqc || !ob_stable)
      begin errors++; $display("FAIL timeout_req_cycles: got %0d stable=%b expected %0d", ob_reqc, ob_stable, e.reqc); end
    checks++; if (!ob_done || ob_lat != e.lat || ob_err !== 1'b1 || ob_rd !== 32'd0)
      begin errors++; $display("FAIL timeout_result: lat=%0d done=%0b err=%b rd=%h expected lat=%0d err=1 rd=0", ob_lat, ob_done, ob_err, ob_rd, e.lat); end
    // a late ack in IDLE must be ignored
    bus.mem_ack_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i); #1;
      checks++; if (bus.done_o !== 1'b0 || bus.mem_req_o !== 1'b0 || bus.rd_data_o !== 32'd0)
        begin errors++; $display("FAIL late_ack%0d: done=%b req=%b rd=%h expected 0 0 0", i, bus.done_o, bus.mem_req_o, bus.rd_data_o); end
    end
    bus.mem_ack_i = 1'b0;
  endtask

  task automatic test_reset_in_req();
    exp_t e;
    // leave non-zero state behind so the reset has something to clear
    push_legal(1'b0, 3'b010, 32'h30C, 32'h0, 32'h0BADF00D, 0);
    run_access(1'b0, 3'b010, 32'h30C, 32'h0, 32'h0BADF00D, 0);
    e = sb.pop_front();
    checks++; if (ob_rd !== e.rd) begin errors++; $display("FAIL pre_reset_load: got %h expected %h", ob_rd, e.rd); end
    bus.req_valid_i = 1; bus.mem_wr_en_i = 0; bus.funct3_i = 3'b010; bus.addr_i = 32'h410; bus.mem_ack_i = 0;
    @(negedge clk_i); #1;
    checks++; if (bus.mem_req_o !== 1'b1) begin errors++; $display("FAIL rst_req_entry: mem_req=%b expected 1", bus.mem_req_o); end
    rst_n_i = 1'b0; bus.req_valid_i = 1'b0;
    @(negedge clk_i); #1;
    checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.done_o, bus.err_o, bus.stall_o} !== 5'b0 ||
        {bus.rd_data_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o} !== 100'b0) begin
      errors++; $display("FAIL rst_in_req: req=%b we=%b done=%b err=%b rd=%h addr=%h wdata=%h be=%b expected all zero",
                         bus.mem_req_o, bus.mem_we_o, bus.done_o, bus.err_o, bus.rd_data_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o);
    end
    rst_n_i = 1'b1; bus.mem_ack_i = 1'b1; model_rd = 32'd0;
    @(negedge clk_i); #1;
    checks++; if (bus.done_o !== 1'b0 || bus.mem_req_o !== 1'b0)
      begin errors++; $display("FAIL rst_late_ack: done=%b req=%b expected 0 0", bus.done_o, bus.mem_req_o); end
    bus.mem_ack_i = 1'b0;
    push_legal(1'b1, 3'b010, 32'h500, 32'h600DCAFE, 32'h0, 0);
    run_access(1'b1, 3'b010, 32'h500, 32'h600DCAFE, 32'h0, 0);
    e = sb.pop_front();
    checks++; if (!ob_done || ob_lat != e.lat || ob_err !== 1'b0 || ob_wdata !== e.wdata || ob_be !== e.be || ob_we !== 1'b1)
      begin errors++; $display("FAIL post_reset_sw: lat=%0d err=%b wdata=%h be=%b we=%b expected lat=%0d err=0 wdata=%h be=%b we=1",
                               ob_lat, ob_err, ob_wdata, ob_be, ob_we, e.lat, e.wdata, e.be); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [2:0]  f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic        we;
    logic [31:0] base, wd, rdata;
    int          ack_at;
    for (int n = 0; n < 20; n++) begin
      f3     = f3s[$urandom_range(0, 4)];
      base   = $urandom & 32'hFFFF_FFFC;
      wd     = $urandom;
      rdata  = $urandom;
      ack_at = $urandom_range(0, 2);
      we     = (f3[2] == 1'b0) ? 1'($urandom_range(0, 1)) : 1'b0;
      case (f3)
        3'b000, 3'b100: lo = 2'($urandom_range(0, 3));
        3'b001, 3'b101: lo = {1'($urandom_range(0, 1)), 1'b0};
        default:        lo = 2'b00;
      endcase
      push_legal(we, f3, base | {30'd0, lo}, wd, rdata, ack_at);
      run_access(we, f3, base | {30'd0, lo}, wd, rdata, ack_at);
      e = sb.pop_front();
      checks++;
      if (!ob_done || ob_lat != e.lat || ob_err !== 1'b0 || ob_rd !== e.rd || ob_rd_held !== e.rd ||
          {ob_we, ob_be, ob_addr, ob_wdata} !== {e.we, e.be, e.addr, e.wdata} || !ob_stable || ob_stall_bad || ob_pulse_bad) begin
        errors++;
        $display("FAIL b2b%0d f3=%b lo=%0d we=%b: lat=%0d rd=%h be=%b addr=%h wdata=%h err=%b expected lat=%0d rd=%h be=%b addr=%h wdata=%h",
                 n, f3, lo, we, ob_lat, ob_rd, ob_be, ob_addr, ob_wdata, ob_err, e.lat, e.rd, e.be, e.addr, e.wdata);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_word();
    test_loads();
    test_store_half();
    test_rejects();
    test_timeout();
    test_reset_in_req();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Parameters
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum cycles spent in REQ waiting for mem_ack_i (legal range 1-255).

Interface
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 clk_i  in  1  clock; all state changes on its rising edge.
REQ-004 rst_n_i  in  1  synchronous active-low reset.
REQ-005 req_valid_i  in  1  CPU requests a load/store; held high until done_o.
REQ-006 mem_wr_en_i  in  1  1 = store, 0 = load (control-unit memory write enable).
REQ-007 funct3_i  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 addr_i  in  32  byte address (ALU result).
REQ-009 wr_data_i  in  32  store data (rs2), right-aligned.
REQ-010 rd_data_o  out  32  extended load result, valid while done_o=1, then held.
REQ-011 done_o  out  1  one-cycle completion pulse.
REQ-012 err_o  out  1  qualifies done_o: misaligned, illegal funct3 or timeout.
REQ-013 stall_o  out  1  freezes the PC and pipeline: req_valid_i & ~done_o, combinational.
REQ-014 mem_req_o, mem_we_o  out  1 each  memory request and write strobe.
REQ-015 mem_addr_o  out  32  word address: {addr_i[31:2], 2'b00}.
REQ-016 mem_wdata_o  out  32  lane-replicated store data.
REQ-017 mem_be_o  out  4  byte lane enables.
REQ-018 mem_ack_i  in  1  memory completes the access this cycle.
REQ-019 mem_rdata_i  in  32  read word, valid when mem_ack_i=1.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ and RESP.
REQ-021 IDLE->REQ: req_valid_i=1 and the access is legal; request fields SHALL be registered on this edge.
REQ-022 IDLE->RESP with err=1: the access is misaligned (H with addr[0]=1; W with addr[1:0]!=0) or funct3 is in {011,110,111}; no memory access is made.
REQ-023 In REQ, mem_req_o=1 and all mem_* outputs SHALL be stable until mem_ack_i=1 is sampled.
REQ-024 REQ->RESP when mem_ack_i=1 (an ack in the first REQ cycle is legal), or when the wait counter reaches TIMEOUT_CYCLES (then err=1 and mem_req_o drops).
REQ-025 In RESP, done_o=1 for exactly one cycle, then the FSM SHALL return to IDLE; a new request is accepted no earlier than the next IDLE cycle.
REQ-026 Minimum latency SHALL be 3 cycles from the accept edge to done_o (accept, REQ with ack, RESP).
REQ-027 mem_be_o SHALL be: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<{addr[1],1'b0}; W 4'b1111.
REQ-028 mem_wdata_o SHALL be: B {4{wd[7:0]}}; H {2{wd[15:0]}}; W wd.
REQ-029 Loads SHALL select the addressed lane of mem_rdata_i, sign-extend it for B/H and zero-extend it for BU/HU/W; the result is registered on the ack edge.
REQ-030 Stores SHALL leave rd_data_o unchanged; an error SHALL force rd_data_o to 0.
REQ-031 The wait counter SHALL be 8 bits, cleared on entry to REQ, and saturating.
REQ-032 A mem_ack_i outside REQ SHALL be ignored.

Reset
REQ-033 With rst_n_i=0 at a clock edge: state SHALL go to IDLE, and mem_req_o, mem_we_o, done_o, err_o and the counter SHALL go to 0; rd_data_o, mem_addr_o, mem_wdata_o and mem_be_o SHALL go to 0.
REQ-034 A reset in REQ SHALL abandon the access with no done_o pulse; a late ack after reset SHALL be ignored.

Verification
REQ-035 SW addr 0x100, wd 0xDEADBEEF, ack in the first REQ cycle -> mem_be_o=1111, mem_we_o=1, done_o at cycle 3, err_o=0.
REQ-036 LB addr 0x103, rdata 0x80FF_FF7F -> mem_be_o=1000, rd_data_o=0xFFFFFF80; LBU -> 0x00000080.
REQ-037 SH addr 0x102, wd 0x1234ABCD -> mem_be_o=1100, mem_wdata_o=0xABCDABCD; LHU addr 0x101 -> err_o=1, mem_req_o never asserted, rd_data_o=0.
REQ-038 LW with ack withheld and TIMEOUT_CYCLES=4 -> mem_req_o high for 4 cycles, then done_o=1 with err_o=1; a late ack is ignored.
REQ-039 rst_n_i=0 during REQ of a load -> next cycle all outputs are 0 and IDLE; a new SW completes normally afterwards.
